// File: rtl/fila_pedidos_if.sv
// ---------------------------------------------------------------------------
// fila_pedidos_if
// Groups the order-stage signals: the raw customer button, the handshake with
// maquina_maluca (start / machine_state) and the status outputs.
//   master : used by fila_pedidos (drives start and status, reads button and
//            machine state)
//   slave  : used by the machine/customer side
// Parameter PEND_W must match the PEND_W of the fila_pedidos instance.
// ---------------------------------------------------------------------------
interface fila_pedidos_if #(
  parameter int PEND_W = 3
);
  logic              botao;
  logic [3:0]        machine_state;
  logic              start;
  logic [PEND_W-1:0] pendentes;
  logic [7:0]        cafes_servidos;
  logic              cafe_pronto;
  logic              ocupado;
  logic              overflow;
  logic              erro;

  modport master (
    input  botao, machine_state,
    output start, pendentes, cafes_servidos, cafe_pronto, ocupado, overflow, erro
  );

  modport slave (
    output botao, machine_state,
    input  start, pendentes, cafes_servidos, cafe_pronto, ocupado, overflow, erro
  );
endinterface

// File: rtl/fila_pedidos.sv
// ---------------------------------------------------------------------------
// fila_pedidos
// Order stage in front of maquina_maluca. Synchronizes and debounces the
// customer button, queues orders in a saturating counter, starts the machine
// only while it reports IDLE and follows its state until the brew is back at
// IDLE. Counts served coffees and flags overflow / illegal machine states.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fila_pedidos_if.master
//            botao          raw asynchronous button (in)
//            machine_state  maquina_maluca state, legal 1..9 (in)
//            start          machine start, high only in S_START (out)
//            pendentes      queued orders not yet accepted (out)
//            cafes_servidos completed brews, wraps at 256 (out)
//            cafe_pronto    one-cycle pulse per completed brew (out)
//            ocupado        FSM not in S_ESPERA (out)
//            overflow       sticky: order arrived with full queue (out)
//            erro           sticky: illegal machine state or timeout (out)
//
// Optional feature: define PEDIDO_TIMEOUT_EN to build a watchdog that aborts a
// brew after TIMEOUT_CYCLES cycles outside S_ESPERA. Without it the FSM waits
// indefinitely and TIMEOUT_CYCLES has no effect.
// ---------------------------------------------------------------------------
module fila_pedidos #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PEND_W          = 3,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  fila_pedidos_if.master bus
);

  typedef enum logic [1:0] {
    S_ESPERA  = 2'd0,
    S_START   = 2'd1,
    S_PREPARO = 2'd2,
    S_FIM     = 2'd3
  } state_t;

  localparam int                DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [3:0]        MS_IDLE  = 4'd1;
  localparam logic [3:0]        MS_LIGAR = 4'd2;
  localparam logic [3:0]        MS_EXTR  = 4'd9;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer for the asynchronous button
  // -------------------------------------------------------------------------
  logic [1:0] sync_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= bus.botao;
        end
      end else begin : g_rest
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Debouncer: the level flips only after DEBOUNCE_CYCLES consecutive samples
  // that disagree with it; any agreeing sample restarts the count.
  // -------------------------------------------------------------------------
  logic            level_reg;
  logic            level_prev_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic            sample;
  logic            order;

  assign sample = sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg      <= 1'b0;
      level_prev_reg <= 1'b0;
      db_cnt_reg     <= '0;
    end else begin
      level_prev_reg <= level_reg;
      if (sample == level_reg) begin
        db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
        level_reg  <= sample;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + DB_W'(1);
      end
    end
  end

  // One order per rising edge of the debounced level
  assign order = level_reg & ~level_prev_reg;

  // -------------------------------------------------------------------------
  // Brew FSM
  // -------------------------------------------------------------------------
  state_t            state_reg;
  state_t            state_next;
  logic [PEND_W-1:0] pend_reg;
  logic [7:0]        cafes_reg;
  logic              pronto_reg;
  logic              overflow_reg;
  logic              erro_reg;
  logic              accept;
  logic              brew_done;
  logic              err_set;
  logic              illegal;
  logic              timeout;

  assign illegal = (bus.machine_state == 4'd0) || (bus.machine_state > MS_EXTR);

`ifdef PEDIDO_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_reg;

  // Restarted when the FSM enters S_START; holds at TO_LAST once reached so
  // the abort fires on the TIMEOUT_CYCLES-th busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= '0;
    end else if (state_reg != S_START && state_next == S_START) begin
      to_cnt_reg <= '0;
    end else if (state_reg != S_ESPERA && to_cnt_reg != TO_LAST) begin
      to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
  end

  assign timeout = (state_reg != S_ESPERA) && (to_cnt_reg == TO_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    brew_done  = 1'b0;
    err_set    = 1'b0;
    if (illegal || timeout) begin
      // Abandon the brew from any state; the queue is left untouched
      err_set    = 1'b1;
      state_next = S_ESPERA;
    end else begin
      case (state_reg)
        S_ESPERA: begin
          if (pend_reg != '0 && bus.machine_state == MS_IDLE) state_next = S_START;
        end
        S_START: begin
          if (bus.machine_state == MS_LIGAR) begin
            accept     = (pend_reg != '0);
            state_next = S_PREPARO;
          end else if (bus.machine_state != MS_IDLE) begin
            state_next = S_ESPERA;
          end
        end
        S_PREPARO: begin
          if (bus.machine_state == MS_EXTR) state_next = S_FIM;
        end
        S_FIM: begin
          if (bus.machine_state == MS_IDLE) begin
            brew_done  = 1'b1;
            state_next = S_ESPERA;
          end
        end
        default: state_next = S_ESPERA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_ESPERA;
      pend_reg     <= '0;
      cafes_reg    <= '0;
      pronto_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      erro_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pronto_reg <= brew_done;
      if (brew_done) cafes_reg <= cafes_reg + 8'd1;
      if (err_set)   erro_reg  <= 1'b1;
      // Order and acceptance together leave the count unchanged; a full
      // queue with no acceptance drops the order.
      if (order && !accept) begin
        if (pend_reg == PEND_MAX) overflow_reg <= 1'b1;
        else                      pend_reg     <= pend_reg + PEND_W'(1);
      end else if (accept && !order) begin
        pend_reg <= pend_reg - PEND_W'(1);
      end
    end
  end

  assign bus.start          = (state_reg == S_START);
  assign bus.ocupado        = (state_reg != S_ESPERA);
  assign bus.pendentes      = pend_reg;
  assign bus.cafes_servidos = cafes_reg;
  assign bus.cafe_pronto    = pronto_reg;
  assign bus.overflow       = overflow_reg;
  assign bus.erro           = erro_reg;

endmodule

// File: tb/tb_fila_pedidos.sv
// ---------------------------------------------------------------------------
// tb_fila_pedidos
// Directed, table-driven bench for fila_pedidos (DEBOUNCE_CYCLES=4, PEND_W=3,
// TIMEOUT_CYCLES=16). A per-cycle vector table covers a full single brew;
// hand-written sequences cover glitches, saturation, simultaneous order and
// acceptance, illegal machine state and the watchdog.
// ---------------------------------------------------------------------------
module tb_fila_pedidos;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ms_drv = 4'd1;
  logic [3:0] model_ms;
  logic       model_en = 1'b0;

  int checks = 0;
  int errors = 0;

  fila_pedidos_if #(.PEND_W(3)) bus ();

  fila_pedidos #(
    .DEBOUNCE_CYCLES(4),
    .PEND_W(3),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.machine_state = model_en ? model_ms : ms_drv;

  // Simple maquina_maluca stand-in: IDLE -> 2 on start, then 3..9, back to IDLE
  always @(posedge clk) begin
    if (!model_en) begin
      model_ms <= 4'd1;
    end else begin
      case (model_ms)
        4'd1:    if (bus.start) model_ms <= 4'd2;
        4'd9:    model_ms <= 4'd1;
        default: model_ms <= model_ms + 4'd1;
      endcase
    end
  end

  typedef struct {
    logic       botao;
    logic [3:0] ms;
    logic       start;
    logic [2:0] pend;
    logic       ocup;
    logic       pronto;
    logic [7:0] cafes;
  } vec_t;

  vec_t tab[19];

  function automatic vec_t mk(input logic b, input logic [3:0] m, input logic s,
                              input logic [2:0] p, input logic o, input logic r,
                              input logic [7:0] c);
    vec_t v;
    v.botao = b; v.ms = m; v.start = s; v.pend = p; v.ocup = o; v.pronto = r; v.cafes = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end else begin
      $display("ok   %s: %0d", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic saw_start;

  // Clean press: long enough high and low phases to debounce both edges
  task automatic press();
    bus.botao = 1'b1;
    for (int i = 0; i < 8; i++) begin step(); saw_start |= bus.start; end
    bus.botao = 1'b0;
    for (int i = 0; i < 8; i++) begin step(); saw_start |= bus.start; end
  endtask

  task automatic do_reset();
    model_en  = 1'b0;
    ms_drv    = 4'd1;
    bus.botao = 1'b0;
    #1;
    rst_n = 1'b0;
    #3;
    check("reset_outputs_low",
          {bus.start, bus.pendentes, bus.cafes_servidos, bus.cafe_pronto,
           bus.ocupado, bus.overflow, bus.erro}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] got, exp;
    int pulses;
    int budget;

    // Single brew, cycle by cycle: inputs applied before each edge, outputs
    // checked just after it.
    tab[0]  = mk(1, 1, 0, 0, 0, 0, 0);
    tab[1]  = mk(1, 1, 0, 0, 0, 0, 0);
    tab[2]  = mk(1, 1, 0, 0, 0, 0, 0);
    tab[3]  = mk(1, 1, 0, 0, 0, 0, 0);
    tab[4]  = mk(1, 1, 0, 0, 0, 0, 0);
    tab[5]  = mk(1, 1, 0, 0, 0, 0, 0);  // debounced level rises here
    tab[6]  = mk(1, 1, 0, 1, 0, 0, 0);  // order queued
    tab[7]  = mk(1, 1, 1, 1, 1, 0, 0);  // S_START
    tab[8]  = mk(1, 1, 1, 1, 1, 0, 0);  // start still high, machine not yet moved
    tab[9]  = mk(1, 2, 0, 0, 1, 0, 0);  // accepted
    tab[10] = mk(0, 3, 0, 0, 1, 0, 0);
    tab[11] = mk(0, 4, 0, 0, 1, 0, 0);
    tab[12] = mk(0, 5, 0, 0, 1, 0, 0);
    tab[13] = mk(0, 6, 0, 0, 1, 0, 0);
    tab[14] = mk(0, 7, 0, 0, 1, 0, 0);
    tab[15] = mk(0, 8, 0, 0, 1, 0, 0);
    tab[16] = mk(0, 9, 0, 0, 1, 0, 0);  // S_FIM
    tab[17] = mk(0, 1, 0, 0, 0, 1, 1);  // brew complete
    tab[18] = mk(0, 1, 0, 0, 0, 0, 1);  // pulse over

    do_reset();

    for (int i = 0; i < 19; i++) begin
      bus.botao = tab[i].botao;
      ms_drv    = tab[i].ms;
      step();
      got = {bus.start, bus.pendentes, bus.ocupado, bus.cafe_pronto,
             bus.cafes_servidos, bus.erro, bus.overflow};
      exp = {tab[i].start, tab[i].pend, tab[i].ocup, tab[i].pronto,
             tab[i].cafes, 2'b00};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d: got start=%b pend=%0d ocup=%b pronto=%b cafes=%0d erro=%b ovf=%b expected start=%b pend=%0d ocup=%b pronto=%b cafes=%0d erro=0 ovf=0",
                 i, got[15], got[14:12], got[11], got[10], got[9:2], got[1], got[0],
                 exp[15], exp[14:12], exp[11], exp[10], exp[9:2]);
      end else begin
        $display("ok   vec%0d: start=%b pend=%0d ocup=%b cafes=%0d", i, got[15], got[14:12], got[11], got[9:2]);
      end
    end

    // Glitchy button: never 4 stable samples in a row
    saw_start = 1'b0;
    for (int r = 0; r < 5; r++) begin
      bus.botao = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); saw_start |= bus.start; end
      bus.botao = 1'b0;
      step(); saw_start |= bus.start;
    end
    for (int i = 0; i < 8; i++) begin step(); saw_start |= bus.start; end
    check("glitch_pendentes", bus.pendentes, 32'd0);
    check("glitch_no_start", saw_start, 32'd0);

    // Saturation with the machine busy in state 5
    do_reset();
    ms_drv    = 4'd5;
    saw_start = 1'b0;
    for (int i = 0; i < 7; i++) press();
    check("sat_pend_7", bus.pendentes, 32'd7);
    check("sat_no_ovf_yet", bus.overflow, 32'd0);
    press();
    press();
    check("sat_pend_held", bus.pendentes, 32'd7);
    check("sat_overflow", bus.overflow, 32'd1);
    check("sat_no_start", saw_start, 32'd0);

    // Release the machine model and serve the whole queue
    model_en = 1'b1;
    pulses   = 0;
    budget   = 0;
    while (!(bus.cafes_servidos == 8'd7 && !bus.ocupado) && budget < 400) begin
      step();
      budget++;
      if (bus.cafe_pronto) pulses++;
    end
    step();
    if (bus.cafe_pronto) pulses++;
    check("serve_cafes_7", bus.cafes_servidos, 32'd7);
    check("serve_pend_0", bus.pendentes, 32'd0);
    check("serve_pulses", pulses, 32'd7);
    check("serve_budget_ok", budget < 400, 32'd1);
    check("serve_ovf_sticky", bus.overflow, 32'd1);
    model_en = 1'b0;

    // Order and acceptance on the same edge with 3 queued
    do_reset();
    ms_drv = 4'd5;
    for (int i = 0; i < 3; i++) press();
    check("simul_pend_pre", bus.pendentes, 32'd3);
    bus.botao = 1'b1;
    for (int i = 0; i < 5; i++) step();
    ms_drv = 4'd1;
    step();
    check("simul_start", {bus.start, bus.pendentes}, {28'd0, 1'b1, 3'd3});
    ms_drv = 4'd2;
    step();
    check("simul_pend_same", {bus.start, bus.ocupado, bus.pendentes}, {27'd0, 2'b01, 3'd3});

    // Illegal machine state while brewing
    bus.botao = 1'b0;
    ms_drv    = 4'd5;
    step();
    check("ill_before", {bus.erro, bus.ocupado}, 32'd1);
    ms_drv = 4'd12;
    step();
    check("ill_erro_idle", {bus.erro, bus.ocupado, bus.pendentes}, {28'd0, 2'b10, 3'd3});
    ms_drv = 4'd5;
    for (int i = 0; i < 4; i++) step();
    check("ill_erro_sticky", bus.erro, 32'd1);

    // Machine stuck in state 2 after acceptance
    do_reset();
    check("erro_cleared", bus.erro, 32'd0);
    ms_drv = 4'd5;
    press();
    ms_drv = 4'd1;
    step();
    ms_drv = 4'd2;
    step();
    for (int i = 0; i < 14; i++) step();
    check("stuck_busy_15", {bus.ocupado, bus.erro}, 32'd2);
    step();
`ifdef PEDIDO_TIMEOUT_EN
    check("stuck_timeout", {bus.ocupado, bus.erro}, 32'd1);
`else
    check("stuck_no_timeout", {bus.ocupado, bus.erro}, 32'd2);
`endif
    for (int i = 0; i < 10; i++) step();
`ifdef PEDIDO_TIMEOUT_EN
    check("stuck_after", {bus.ocupado, bus.erro, bus.pendentes}, {27'd0, 2'b01, 3'd0});
`else
    check("stuck_after", {bus.ocupado, bus.erro, bus.pendentes}, {27'd0, 2'b10, 3'd0});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
